// File: rtl/rggen_wishbone_slave_adapter.sv
// Wishbone B4 slave front-end for an rggen register bus.
// Accepts one request at a time; ack/err/dat_r are registered.
module rggen_wishbone_slave_adapter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter bit USE_STALL     = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic [ADDRESS_WIDTH-1:0]  i_wb_adr,
    input  logic                      i_wb_we,
    input  logic [DATA_WIDTH-1:0]     i_wb_dat_w,
    input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                      o_wb_stall,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic                      o_wb_rty,
    output logic [DATA_WIDTH-1:0]     o_wb_dat_r,
    output logic                      o_bus_valid,
    output logic [1:0]                o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
    output logic [DATA_WIDTH-1:0]     o_bus_write_data,
    output logic [DATA_WIDTH/8-1:0]   o_bus_strobe,
    input  logic                      i_bus_ready,
    input  logic [1:0]                i_bus_status,
    input  logic [DATA_WIDTH-1:0]     i_bus_read_data
);

    localparam logic [1:0] RGGEN_READ   = 2'b10;
    localparam logic [1:0] RGGEN_WRITE  = 2'b11;
    localparam logic [1:0] RGGEN_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        RESPONSE = 2'd2
    } state_e;

    state_e                     state_q;
    logic                       abort_q;
    logic                       valid_q;
    logic                       stall_q;
    logic                       ack_q;
    logic                       err_q;
    logic                       we_q;
    logic [ADDRESS_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]      wdat_q;
    logic [DATA_WIDTH/8-1:0]    sel_q;
    logic [DATA_WIDTH-1:0]      rdat_q;

    logic bus_ok;
    logic aborted;

    assign bus_ok  = (i_bus_status == RGGEN_OKAY) ||
                     (i_bus_status == RGGEN_EXOKAY);
    // a drop of cyc in the completing cycle counts as an abort too
    assign aborted = abort_q || !i_wb_cyc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        state_q <= REQUEST;
                        abort_q <= 1'b0;
                        valid_q <= 1'b1;
                        stall_q <= USE_STALL;
                        we_q    <= i_wb_we;
                        adr_q   <= i_wb_adr;
                        wdat_q  <= i_wb_dat_w;
                        sel_q   <= i_wb_sel;
                    end
                end
                REQUEST: begin
                    if (!i_wb_cyc) begin
                        abort_q <= 1'b1;
                    end
                    if (i_bus_ready) begin
                        valid_q <= 1'b0;
                        if (aborted) begin
                            state_q <= IDLE;
                            stall_q <= 1'b0;
                        end else begin
                            state_q <= RESPONSE;
                            ack_q   <= bus_ok;
                            err_q   <= !bus_ok;
                            if (bus_ok && !we_q) begin
                                rdat_q <= i_bus_read_data;
                            end
                        end
                    end
                end
                RESPONSE: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_wb_stall       = stall_q;
    assign o_wb_ack         = ack_q && i_wb_cyc;
    assign o_wb_err         = err_q && i_wb_cyc;
    assign o_wb_rty         = 1'b0;
    assign o_wb_dat_r       = i_wb_cyc ? rdat_q : '0;
    assign o_bus_valid      = valid_q;
    assign o_bus_access     = we_q ? RGGEN_WRITE : RGGEN_READ;
    assign o_bus_address    = adr_q;
    assign o_bus_write_data = wdat_q;
    assign o_bus_strobe     = sel_q;

endmodule

// File: tb/tb_rggen_wishbone_slave_adapter.sv
// Bench for rggen_wishbone_slave_adapter: pipelined and classic
// instances share stimulus; expectations come from latency rules.
module tb_rggen_wishbone_slave_adapter;

    localparam logic [1:0] RD    = 2'b10;
    localparam logic [1:0] WR    = 2'b11;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] EXOK  = 2'b01;
    localparam logic [1:0] SLVER = 2'b10;
    localparam logic [1:0] DECER = 2'b11;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [1:0]  status;
        logic [31:0] rdata;
        int          wt;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, ready;
    logic [15:0] adr;
    logic [31:0] dat_w, rdata;
    logic [3:0]  sel;
    logic [1:0]  status;

    logic        p_stall, p_ack, p_err, p_rty, p_valid;
    logic [31:0] p_dat_r, p_wdata;
    logic [1:0]  p_access;
    logic [15:0] p_address;
    logic [3:0]  p_strobe;
    logic        c_stall, c_ack, c_err, c_rty, c_valid;
    logic [31:0] c_dat_r, c_wdata;
    logic [1:0]  c_access;
    logic [15:0] c_address;
    logic [3:0]  c_strobe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rggen_wishbone_slave_adapter #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .USE_STALL(1'b1)
    ) dut_p (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat_w(dat_w),
        .i_wb_sel(sel), .o_wb_stall(p_stall), .o_wb_ack(p_ack),
        .o_wb_err(p_err), .o_wb_rty(p_rty), .o_wb_dat_r(p_dat_r),
        .o_bus_valid(p_valid), .o_bus_access(p_access),
        .o_bus_address(p_address), .o_bus_write_data(p_wdata),
        .o_bus_strobe(p_strobe), .i_bus_ready(ready),
        .i_bus_status(status), .i_bus_read_data(rdata)
    );

    rggen_wishbone_slave_adapter #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .USE_STALL(1'b0)
    ) dut_c (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_adr(adr), .i_wb_we(we), .i_wb_dat_w(dat_w),
        .i_wb_sel(sel), .o_wb_stall(c_stall), .o_wb_ack(c_ack),
        .o_wb_err(c_err), .o_wb_rty(c_rty), .o_wb_dat_r(c_dat_r),
        .o_bus_valid(c_valid), .o_bus_access(c_access),
        .o_bus_address(c_address), .o_bus_write_data(c_wdata),
        .o_bus_strobe(c_strobe), .i_bus_ready(ready),
        .i_bus_status(status), .i_bus_read_data(rdata)
    );

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Reference: response kind and read data from the status rules.
    function automatic vec_t model(vec_t t);
        vec_t r = t;
        logic ok = (t.status == OKAY) || (t.status == EXOK);
        r.exp_ack = ok;
        r.exp_err = !ok;
        r.exp_dat = (ok && !t.we) ? t.rdata : 32'h0;
        return r;
    endfunction

    task automatic check_outs(input string tag, input logic ev,
                              input logic [1:0] ea, input logic [15:0] eadr,
                              input logic [31:0] ewd, input logic [3:0] esel,
                              input logic est, input logic eack,
                              input logic eerr, input logic [31:0] edat);
        chk({tag, ".p_valid"}, 64'(p_valid), 64'(ev));
        chk({tag, ".c_valid"}, 64'(c_valid), 64'(ev));
        chk({tag, ".p_stall"}, 64'(p_stall), 64'(est));
        chk({tag, ".c_stall"}, 64'(c_stall), 64'(0));
        chk({tag, ".p_ack"}, 64'(p_ack), 64'(eack));
        chk({tag, ".c_ack"}, 64'(c_ack), 64'(eack));
        chk({tag, ".p_err"}, 64'(p_err), 64'(eerr));
        chk({tag, ".c_err"}, 64'(c_err), 64'(eerr));
        chk({tag, ".p_dat_r"}, 64'(p_dat_r), 64'(edat));
        chk({tag, ".c_dat_r"}, 64'(c_dat_r), 64'(edat));
        chk({tag, ".rty"}, 64'({p_rty, c_rty}), 64'(0));
        if (ev) begin
            chk({tag, ".p_access"}, 64'(p_access), 64'(ea));
            chk({tag, ".c_access"}, 64'(c_access), 64'(ea));
            chk({tag, ".p_addr"}, 64'(p_address), 64'(eadr));
            chk({tag, ".c_addr"}, 64'(c_address), 64'(eadr));
            chk({tag, ".p_wdata"}, 64'(p_wdata), 64'(ewd));
            chk({tag, ".c_wdata"}, 64'(c_wdata), 64'(ewd));
            chk({tag, ".p_strobe"}, 64'(p_strobe), 64'(esel));
            chk({tag, ".c_strobe"}, 64'(c_strobe), 64'(esel));
        end
    endtask

    task automatic check_reset(input string tag);
        check_outs(tag, 1'b0, RD, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, ".p_access"}, 64'(p_access), 64'(RD));
        chk({tag, ".c_access"}, 64'(c_access), 64'(RD));
        chk({tag, ".addr"}, 64'({p_address, c_address}), 64'(0));
        chk({tag, ".wdata"}, 64'({p_wdata, c_wdata}), 64'(0));
        chk({tag, ".strobe"}, 64'({p_strobe, c_strobe}), 64'(0));
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        cyc = 1'($urandom);
        stb = cyc ? 1'b0 : 1'($urandom);
        ready = 1'($urandom);
        #1 check_outs(tag, 1'b0, RD, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_txn(input vec_t t, input bit classic, input string tag);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = t.we; adr = t.adr;
        dat_w = t.wdat; sel = t.sel; ready = 1'b0;
        #1 check_outs({tag, ".C"}, 1'b0, RD, 16'h0, 32'h0, 4'h0,
                      1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= t.wt; k++) begin
            @(posedge clk); #1;
            stb = classic; we = ~t.we; adr = 16'($urandom);
            dat_w = $urandom; sel = 4'($urandom);
            ready = (k == t.wt); status = t.status; rdata = t.rdata;
            #1 check_outs({tag, ".req"}, 1'b1, t.we ? WR : RD, t.adr,
                          t.wdat, t.sel, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        @(posedge clk); #1;
        stb = classic; ready = 1'($urandom);
        status = 2'($urandom); rdata = $urandom;
        #1 check_outs({tag, ".rsp"}, 1'b0, RD, 16'h0, 32'h0, 4'h0,
                      1'b1, t.exp_ack, t.exp_err, t.exp_dat);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, OKAY,
                   32'hAAAA5555, 1, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 16'h0024, 32'h0, 4'hF, OKAY,
                   32'h12345678, 4, 1'b1, 1'b0, 32'h12345678};
        tbl[2] = '{1'b0, 16'h0030, 32'h0, 4'hF, DECER,
                   32'h55AA55AA, 1, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 16'h0034, 32'h01020304, 4'h5, SLVER,
                   32'h77777777, 2, 1'b0, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 16'h0040, 32'h0, 4'h3, EXOK,
                   32'hCAFEF00D, 2, 1'b1, 1'b0, 32'hCAFEF00D};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
        dat_w = '0; sel = '0; ready = 1'b0; status = OKAY; rdata = '0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        end
        idle_cycle("gap");

        // classic: stb held through the response, then back-to-back
        run_txn(tbl[0], 1'b1, "classic0");
        run_txn(tbl[1], 1'b1, "classic1");
        idle_cycle("classic_end");

        // abort: cyc drops in C+2, ready in C+3
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0050; sel = 4'hF;
        ready = 1'b0;
        #1 check_outs("ab.C", 1'b0, RD, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        stb = 1'b0;
        #1 check_outs("ab.C1", 1'b1, RD, 16'h0050, dat_w, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b0;
        #1 check_outs("ab.C2", 1'b1, RD, 16'h0050, dat_w, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        ready = 1'b1; status = OKAY; rdata = 32'h0BADF00D;
        #1 check_outs("ab.C3", 1'b1, RD, 16'h0050, dat_w, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0);
        run_txn(tbl[4], 1'b0, "ab.next");

        // reset while a write is pending
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0060;
        dat_w = 32'h600DCAFE; sel = 4'hC; ready = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        #1 check_outs("rs.C1", 1'b1, WR, 16'h0060, 32'h600DCAFE, 4'hC,
                      1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1; status = OKAY;
        #1 check_reset("rs.C3");
        @(posedge clk); #1;
        ready = 1'b0;
        #1 check_outs("rs.C4", 1'b0, RD, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            rv.we = 1'($urandom);
            rv.adr = 16'($urandom);
            rv.wdat = $urandom;
            rv.sel = 4'($urandom);
            rv.status = 2'($urandom);
            rv.rdata = $urandom;
            rv.wt = $urandom_range(1, 4);
            rv = model(rv);
            run_txn(rv, 1'($urandom), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) idle_cycle("rnd_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
